// File: rtl/mdu.sv
// E-stage multiply/divide unit. It holds the architectural HI/LO registers and
// runs MULT/MULTU/DIV/DIVU with a fixed busy latency. The result is computed
// when the op is accepted and parked in a shadow register. It is committed to
// HI/LO when the busy count expires.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic        md_stall_src,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  // ok=0 marks a divide by zero: the op runs its full latency but commits nothing
  typedef struct packed {
    logic        ok;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [31:0]     hi_n, lo_n;
  md_res_t         sh, sh_n, res;
  logic            is_mult, is_md;
  logic [63:0]     prod_s, prod_u;
  logic [31:0]     dsr, sq, sr, uq, ur;

  assign is_mult = (op == OP_MULT) || (op == OP_MULTU);
  assign is_md   = is_mult || (op == OP_DIV) || (op == OP_DIVU);

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // A zero divisor is replaced so the datapath never sees x/0.
  // For 0x80000000 / -1, dividing by 1 gives exactly lo=0x80000000, hi=0.
  assign dsr = ((b == 32'd0) || ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)))
               ? 32'd1 : b;
  assign sq  = $signed(a) / $signed(dsr);
  assign sr  = $signed(a) % $signed(dsr);
  assign uq  = a / dsr;
  assign ur  = a % dsr;

  // Result of the op presented this cycle
  always_comb begin
    res    = '0;
    res.ok = 1'b1;
    case (op)
      OP_MULT:  {res.hi, res.lo} = prod_s;
      OP_MULTU: {res.hi, res.lo} = prod_u;
      OP_DIV:   begin res.ok = (b != 32'd0); res.hi = sr; res.lo = sq; end
      OP_DIVU:  begin res.ok = (b != 32'd0); res.hi = ur; res.lo = uq; end
      default:  ;
    endcase
  end

  // Next state: accept md/mt ops in IDLE, count down and commit in BUSY
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    sh_n    = sh;
    case (state)
      IDLE: begin
        if (is_md) begin
          sh_n    = res;
          cnt_n   = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          state_n = BUSY;
        end else if (op == OP_MTHI) begin
          hi_n = a;
        end else if (op == OP_MTLO) begin
          lo_n = a;
        end
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          if (sh.ok) begin
            hi_n = sh.hi;
            lo_n = sh.lo;
          end
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; async reset aborts any in-flight op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      sh    <= sh_n;
    end
  end

  assign start        = is_md && (state == IDLE);
  assign busy         = (state == BUSY);
  assign md_stall_src = start | busy;

  // MFHI/MFLO read port
  always_comb begin
    rd_data = '0;
    if (op == OP_MFHI)      rd_data = hi;
    else if (op == OP_MFLO) rd_data = lo;
  end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: a timeline model (commit edge number + precomputed result)
// checked against every output on each falling edge, plus directed literal checks.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        start, busy, md_stall_src;
  logic [31:0] hi, lo, rd_data;

  int tot = 0;
  int bad = 0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .op(op), .a(a), .b(b),
    .start(start), .busy(busy), .md_stall_src(md_stall_src),
    .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot = tot + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: {ok, hi, lo}
  function automatic logic [64:0] md_ref(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int          sx, sy;
    longint      ps;
    logic [63:0] pu;
    sx = x; sy = y;
    case (o)
      4'd1: begin ps = longint'(sx) * longint'(sy); return {1'b1, ps[63:0]}; end
      4'd2: begin pu = {32'd0, x} * {32'd0, y}; return {1'b1, pu}; end
      4'd3: begin
        if (y == 0) return {1'b0, 64'd0};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b1, 32'd0, 32'h8000_0000};
        return {1'b1, 32'(sx % sy), 32'(sx / sy)};
      end
      4'd4: begin
        if (y == 0) return {1'b0, 64'd0};
        return {1'b1, x % y, x / y};
      end
      default: return 65'd0;
    endcase
  endfunction

  // Model: an accepted op at edge e0 commits at edge e0+N; busy in between
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        pend, p_ok;
  int          e, end_e;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= 0; m_lo <= 0; pend <= 0; e <= 0; end_e <= 0;
      p_hi <= 0; p_lo <= 0; p_ok <= 0;
    end else begin
      e <= e + 1;
      if (pend) begin
        if (e + 1 == end_e) begin
          pend <= 0;
          if (p_ok) begin m_hi <= p_hi; m_lo <= p_lo; end
        end
      end else if (op >= 4'd1 && op <= 4'd4) begin
        pend  <= 1;
        end_e <= e + 1 + ((op <= 4'd2) ? MC : DC);
        {p_ok, p_hi, p_lo} <= md_ref(op, a, b);
      end else if (op == 4'd7) m_hi <= a;
      else if (op == 4'd8) m_lo <= a;
    end
  end

  // Cycle compare against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("start", start, !pend && op >= 4'd1 && op <= 4'd4);
      chk("busy", busy, pend);
      chk("stall", md_stall_src, pend || (op >= 4'd1 && op <= 4'd4));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("rd_data", rd_data, op == 4'd5 ? m_hi : (op == 4'd6 ? m_lo : 32'd0));
    end
  end

  task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    op = o; a = x; b = y;
  endtask

  // Issue one md op for one cycle, then count busy cycles (bounded)
  task automatic run_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int n, input string nm);
    int nb;
    drive(o, x, y);
    @(negedge clk);
    chk({nm, "_start"}, start, 1'b1);
    drive(4'd0, 0, 0);
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
    chk({nm, "_busy_cycles"}, nb, n);
  endtask

  initial begin
    reset = 1'b0; op = 0; a = 0; b = 0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", hi, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // 1: reset low mid-stream
    drive(4'd7, 32'h99, 0);
    drive(4'd5, 0, 0);
    @(negedge clk);
    chk("mthi_99", rd_data, 32'h99);
    #2 reset = 1'b0;
    #1;
    chk("rst1_hi", hi, 0);
    chk("rst1_lo", lo, 0);
    chk("rst1_busy", busy, 1'b0);
    chk("rst1_start", start, 1'b0);
    chk("rst1_rd", rd_data, 0);
    @(negedge clk); reset = 1'b1;

    // 2: MULT / MULTU
    run_md(4'd1, 32'hFFFF_FFFE, 32'd3, MC, "mult");
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    run_md(4'd2, 32'hFFFF_FFFE, 32'd3, MC, "multu");
    chk("multu_hi", hi, 32'h2);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    // 3: DIV / DIVU / overflow corner
    run_md(4'd3, 32'hFFFF_FFF9, 32'd2, DC, "div");
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_md(4'd4, 32'd7, 32'd2, DC, "divu");
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, "divovf");
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    // 4: divide by zero leaves hi/lo
    drive(4'd7, 32'h11, 0);
    drive(4'd8, 32'h22, 0);
    run_md(4'd3, 32'd5, 32'd0, DC, "div0");
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);
    drive(4'd5, 0, 0);
    @(negedge clk);
    chk("div0_mfhi", rd_data, 32'h11);

    // 5: MT ignored / MF old while busy; back-to-back start as busy falls
    drive(4'd1, 32'd3, 32'd4);
    drive(4'd8, 32'h55, 0);
    drive(4'd6, 0, 0);
    @(negedge clk);
    chk("busy_mflo", rd_data, 32'h22);
    drive(4'd3, 32'd100, 32'd7);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("b2b_lo", lo, 32'd12);
    chk("b2b_hi", hi, 32'd0);
    chk("b2b_start", start, 1'b1);
    drive(4'd0, 0, 0);
    @(negedge clk);
    chk("b2b_busy", busy, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("b2b_div_lo", lo, 32'd14);
    chk("b2b_div_hi", hi, 32'd2);

    // 6: async reset during DIV aborts it
    drive(4'd3, 32'd50, 32'd3);
    drive(4'd0, 0, 0);
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("abort_busy_pre", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_stall", md_stall_src, 1'b0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 15; k++) @(negedge clk);
    chk("abort_nocommit_hi", hi, 0);
    chk("abort_nocommit_lo", lo, 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- E-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Holds the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency.
- Exports busy/start status that the hazard stall logic uses to freeze D-stage mult/div and mf/mt instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; clears all state immediately
op  input  4  E-stage MD op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, others = none
a  input  32  rs operand (E-stage, already forwarded)
b  input  32  rt operand (E-stage, already forwarded)
start  output  1  combinational: op in {1..4} and state IDLE
busy  output  1  registered: state BUSY
md_stall_src  output  1  start | busy; consumed by the stall logic
hi  output  32  architectural HI
lo  output  32  architectural LO
rd_data  output  32  combinational: hi when op=MFHI, lo when op=MFLO, else 0

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, hi=lo=0, shadow hi/lo=0, busy=0. Any in-flight operation is aborted and its result discarded.
- States:
  - IDLE:
    - On a clock edge with op in {1..4}, latch the computed 64-bit result into shadow regs.
    - Load cnt = MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
    - Go to BUSY.
  - BUSY:
    - Decrement cnt each edge.
    - On the edge where cnt==1: commit shadow to hi/lo, set cnt=0, go to IDLE.
- Latency: start sampled at edge T0. busy=1 during cycles T0+1 .. T0+N. New hi/lo are visible in the cycle after edge T0+N, the same cycle busy falls.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIV special case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned.
  - Divide by zero (b==0, DIV or DIVU): the op still takes DIV_CYCLES with busy asserted, but hi/lo are left unchanged at commit.
- MTHI/MTLO in IDLE: hi (or lo) <= a on the edge; takes effect in the next cycle; busy is unaffected.
- MFHI/MFLO read the current architectural hi/lo combinationally with no latency.
- Any op arriving while BUSY is ignored: no state change, no restart. The stall logic guarantees this never occurs; it is listed for robustness only.
- MF* while BUSY returns the old (pre-commit) hi/lo.
- MT* while BUSY is ignored; the committed result wins.
- Back-to-back: a new mult/div may start in the cycle immediately after busy falls (IDLE at that edge).
- Stall contract: the stall logic stalls D when the D instruction is a mult/div/mf/mt and md_stall_src=1. md_stall_src depends only on E-stage op and registered state; it has no combinational path from a/b.

Test Plan:
1. Reset low mid-stream, release -> hi=0, lo=0, busy=0, start=0, rd_data=0.
2. op=MULT, a=0xFFFFFFFE (-2), b=3 for one cycle, then op=0 -> start=1 that cycle; busy=1 for exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
3. op=DIV, a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
4. Preload hi=0x11, lo=0x22 via MTHI/MTLO; then DIV with b=0 -> busy 10 cycles; hi=0x11, lo=0x22 after; MFHI gives rd_data=0x11.
5. Start MULT, during busy apply MTLO a=0x55 and MFLO -> MTLO ignored, rd_data = old lo; after commit lo = product. Start DIV on the cycle busy falls -> accepted, busy re-asserts next cycle.
6. Start DIV, assert reset at busy cycle 4 -> busy=0 and hi=lo=0 immediately (asynchronously, without a clock edge); no later commit occurs.
